// File: rtl/donkey_ctl.sv
// donkey_ctl: per-frame motion controller for the donkey sprite.
//
// The controller reads the player controls once per video frame, on the rising
// edge of vblnk, and updates the sprite's top-left position. Horizontal motion
// is clamped to the screen. Vertical motion is a gravity-driven jump with three
// states: GROUND, AIR and LAND. All outputs are registered and change only on
// the clock edge that ends the tick cycle, so motion never changes mid-frame.
//
// Ports:
//   clk        in   system pixel clock
//   rst        in   synchronous reset, active-low (0 = reset)
//   vblnk      in   vertical blank; a frame tick is its rising edge
//   move_left  in   level, player holds left
//   move_right in   level, player holds right
//   jump       in   level, player holds jump
//   xpos       out  [10:0] sprite x position, unsigned
//   ypos       out  [10:0] sprite y position, unsigned
//   mirror     out  1 = sprite faces left
//   airborne   out  1 while the vertical FSM is in AIR

module donkey_ctl #(
    parameter int X_INIT   = 10,
    parameter int Y_GROUND = 500,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 976,
    parameter int STEP     = 2,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        mirror,
    output logic        airborne
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_AIR    = 2'd1,
        ST_LAND   = 2'd2
    } state_t;

    // 12-bit signed views of the position limits and step
    localparam logic signed [11:0] X_MIN_S    = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S    = 12'(X_MAX);
    localparam logic signed [11:0] STEP_S     = 12'(STEP);
    localparam logic signed [11:0] Y_GROUND_S = 12'(Y_GROUND);
    localparam logic signed [11:0] X_INIT_S   = 12'(X_INIT);
    localparam logic signed [8:0]  VEL_MIN    = -9'sd128;

    state_t             state_q, state_d;
    logic               vblnk_q;
    logic               armed_q, armed_d;
    logic               tick;
    logic [10:0]        xpos_q, xpos_d;
    logic [10:0]        ypos_q, ypos_d;
    logic               mirror_q, mirror_d;
    logic signed [7:0]  vel_q, vel_d;

    logic signed [11:0] x_cur;
    logic signed [11:0] x_left;
    logic signed [11:0] x_right;
    logic signed [11:0] y_next;
    logic signed [8:0]  vel_dec;

    // ------------------------------------------------------------------
    // Frame tick detection.
    // vblnk_q is forced low in reset, so a vblnk already high at reset
    // release would look like a rising edge. armed_q blocks the tick until
    // vblnk has been seen low at least once after reset.
    // ------------------------------------------------------------------
    assign armed_d = armed_q | ~vblnk;
    assign tick    = vblnk & ~vblnk_q & armed_q;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_GROUND;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            vblnk_q  <= 1'b0;
            armed_q  <= 1'b0;
            xpos_q   <= X_INIT_S[10:0];
            ypos_q   <= Y_GROUND_S[10:0];
            mirror_q <= 1'b0;
            vel_q    <= 8'sd0;
        end else begin
            vblnk_q  <= vblnk;
            armed_q  <= armed_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            mirror_q <= mirror_d;
            vel_q    <= vel_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_GROUND: if (jump) state_d = ST_AIR;
                ST_AIR:    if (y_next >= Y_GROUND_S) state_d = ST_LAND;
                ST_LAND:   if (!jump) state_d = ST_GROUND;
                default:   state_d = ST_GROUND;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Horizontal datapath: widen to signed 12 bits so x - STEP cannot wrap
    // below zero before the clamp.
    // ------------------------------------------------------------------
    always_comb begin
        x_cur    = $signed({1'b0, xpos_q});
        x_left   = x_cur - STEP_S;
        x_right  = x_cur + STEP_S;
        xpos_d   = xpos_q;
        mirror_d = mirror_q;
        if (tick) begin
            if (move_left && !move_right) begin
                xpos_d   = (x_left < X_MIN_S) ? X_MIN_S[10:0] : x_left[10:0];
                mirror_d = 1'b1;
            end else if (move_right && !move_left) begin
                xpos_d   = (x_right > X_MAX_S) ? X_MAX_S[10:0] : x_right[10:0];
                mirror_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vertical datapath: velocity is positive going up, so the new y is
    // ypos - velocity. The velocity decrement saturates at -128.
    // ------------------------------------------------------------------
    always_comb begin
        y_next  = $signed({1'b0, ypos_q}) - $signed({{4{vel_q[7]}}, vel_q});
        vel_dec = $signed({vel_q[7], vel_q}) - $signed(9'(GRAVITY));
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        if (tick) begin
            unique case (state_q)
                ST_GROUND: begin
                    if (jump) vel_d = 8'(JUMP_V0);
                end
                ST_AIR: begin
                    if (y_next >= Y_GROUND_S) begin
                        ypos_d = Y_GROUND_S[10:0];
                        vel_d  = 8'sd0;
                    end else begin
                        ypos_d = (y_next < 12'sd0) ? 11'd0 : y_next[10:0];
                        vel_d  = (vel_dec < VEL_MIN) ? VEL_MIN[7:0] : vel_dec[7:0];
                    end
                end
                default: begin
                    ypos_d = ypos_q;
                    vel_d  = vel_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        airborne = (state_q == ST_AIR);
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign mirror = mirror_q;

endmodule

// File: tb/tb_donkey_ctl.sv
// tb_donkey_ctl: scoreboard bench for donkey_ctl.
// The driver issues one frame at a time and pushes the hand-computed expected
// outputs for that frame. The monitor pops an entry once the update edge after
// its push has passed. On every other cycle it checks that the outputs hold
// the last expected values.

module tb_donkey_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk;
    logic        move_left;
    logic        move_right;
    logic        jump;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        mirror;
    logic        airborne;

    typedef struct {
        time   t;
        int    x;
        int    y;
        bit    m;
        bit    air;
        string name;
    } exp_t;

    exp_t  q[$];
    exp_t  cur;
    bit    have_cur = 1'b0;
    time   last_pos = 0;
    int    passed   = 0;
    int    total    = 0;

    // Expected outputs, maintained by the driver.
    int    ex_x;
    int    ex_y;
    bit    ex_m;
    bit    ex_air;

    // Hand-computed ypos after each AIR tick of a full jump (v0=12, g=1).
    int    jy[25];

    donkey_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .xpos       (xpos),
        .ypos       (ypos),
        .mirror     (mirror),
        .airborne   (airborne)
    );

    always #5 clk = ~clk;

    always @(posedge clk) last_pos = $time;

    task automatic check(input string name, input exp_t e);
        total++;
        if (xpos !== 11'(e.x) || ypos !== 11'(e.y) || mirror !== e.m || airborne !== e.air) begin
            $display("FAIL %s @%0t: got x=%0d y=%0d mirror=%0b airborne=%0b, expected x=%0d y=%0d mirror=%0b airborne=%0b",
                     name, $time, xpos, ypos, mirror, airborne, e.x, e.y, e.m, e.air);
        end else begin
            passed++;
        end
    endtask

    task automatic push(input string name);
        exp_t e;
        e.t    = $time;
        e.x    = ex_x;
        e.y    = ex_y;
        e.m    = ex_m;
        e.air  = ex_air;
        e.name = name;
        q.push_back(e);
    endtask

    // One frame: keys applied while vblnk is low, then vblnk rises and stays
    // high for hi cycles. The tick happens on the first edge with vblnk high.
    task automatic frm(input bit l, input bit r, input bit j, input int hi, input string name);
        @(posedge clk);
        #1;
        move_left  = l;
        move_right = r;
        jump       = j;
        vblnk      = 1'b0;
        @(posedge clk);
        #1;
        vblnk = 1'b1;
        push(name);
        repeat (hi) @(posedge clk);
    endtask

    // Runs the 25 AIR ticks of a full jump with the jump key at level j.
    task automatic full_jump(input bit j, input string name);
        for (int i = 0; i < 25; i++) begin
            ex_y   = jy[i];
            ex_air = (i < 24);
            frm(1'b0, 1'b0, j, 2, name);
        end
    endtask

    task automatic sync_reset(input string name);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ex_x   = 10;
        ex_y   = 500;
        ex_m   = 1'b0;
        ex_air = 1'b0;
        push(name);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare a due entry, otherwise check that the outputs hold.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].t < last_pos) begin
                cur      = q.pop_front();
                have_cur = 1'b1;
                check(cur.name, cur);
            end else if (have_cur) begin
                check({cur.name, "_hold"}, cur);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        jy = '{488, 477, 467, 458, 450, 443, 437, 432, 428, 425, 423, 422, 422,
               423, 425, 428, 432, 437, 443, 450, 458, 467, 477, 488, 500};

        // Reset with vblnk already high. It stays high, with right held,
        // across release, so any spurious tick would move x.
        rst        = 1'b0;
        vblnk      = 1'b1;
        move_left  = 1'b0;
        move_right = 1'b0;
        jump       = 1'b0;
        ex_x       = 10;
        ex_y       = 500;
        ex_m       = 1'b0;
        ex_air     = 1'b0;
        push("reset");
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b1;
        move_right = 1'b1;
        repeat (5) @(posedge clk);

        // 1: idle frames, nothing moves
        for (int i = 0; i < 5; i++) frm(1'b0, 1'b0, 1'b0, 2, "idle");

        // 2: left clamps at X_MIN: 8,6,4,2,0,0,...
        for (int i = 0; i < 10; i++) begin
            ex_x = (ex_x >= 2) ? ex_x - 2 : 0;
            ex_m = 1'b1;
            frm(1'b1, 1'b0, 1'b0, 2, "left");
        end

        // 3: right up to and past X_MAX
        for (int i = 0; i < 492; i++) begin
            ex_x = (ex_x + 2 > 976) ? 976 : ex_x + 2;
            ex_m = 1'b0;
            frm(1'b0, 1'b1, 1'b0, 1, (i >= 488) ? "right_sat" : "right");
        end
        ex_x = 974;
        ex_m = 1'b1;
        frm(1'b1, 1'b0, 1'b0, 2, "left_one");
        for (int i = 0; i < 3; i++) frm(1'b1, 1'b1, 1'b0, 2, "both_keys");
        for (int i = 0; i < 2; i++) frm(1'b0, 1'b0, 1'b0, 2, "no_keys");
        ex_x = 976;
        ex_m = 1'b0;
        frm(1'b0, 1'b1, 1'b0, 2, "right_back");

        // 4: one-frame jump pulse
        ex_air = 1'b1;
        frm(1'b0, 1'b0, 1'b1, 2, "jump_start");
        full_jump(1'b0, "jump_air");
        frm(1'b0, 1'b0, 1'b0, 2, "land_to_ground");

        // 5: held jump gives one jump, then waits in LAND for release
        ex_air = 1'b1;
        frm(1'b0, 1'b0, 1'b1, 2, "held_start");
        full_jump(1'b1, "held_air");
        for (int i = 0; i < 3; i++) frm(1'b0, 1'b0, 1'b1, 2, "held_land");
        frm(1'b0, 1'b0, 1'b0, 2, "held_release");
        ex_air = 1'b1;
        frm(1'b0, 1'b0, 1'b1, 2, "rejump");
        for (int i = 0; i < 5; i++) begin
            ex_y = jy[i];
            frm(1'b0, 1'b0, 1'b0, 2, "rejump_air");
        end

        // 6a: reset mid-jump at ypos=450
        sync_reset("reset_mid_jump");
        for (int i = 0; i < 2; i++) frm(1'b0, 1'b0, 1'b0, 2, "after_reset");
        ex_air = 1'b1;
        frm(1'b0, 1'b0, 1'b1, 2, "jump_after_reset");
        full_jump(1'b0, "post_reset_air");
        frm(1'b0, 1'b0, 1'b0, 2, "post_reset_ground");

        // 6b: vblnk held high for a long time is still one tick
        ex_x = 12;
        frm(1'b0, 1'b1, 1'b0, 20, "long_vblnk");
        ex_x = 14;
        frm(1'b0, 1'b1, 1'b0, 2, "after_long_vblnk");

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
        end else begin
            passed++;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
